// File: rtl/aipp_dispatch_pkg.sv
// Shared types and constants for the token-lease dispatcher.
package aipp_dispatch_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StArmed,
        StRun,
        StDrain
    } ch_state_e;

    // A token is only valid when this low field of its payload is non-zero.
    localparam int unsigned TOKEN_LOW_W = 64;

endpackage

// File: rtl/aipp_lease_channel.sv
// One ALU cluster channel: lease-bounded RUN with a fixed clock drain afterwards.
module aipp_lease_channel
    import aipp_dispatch_pkg::*;
#(
    parameter int unsigned LEASE_W      = 16,
    parameter int unsigned DRAIN_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tok_load,
    input  logic [LEASE_W-1:0] tok_lease,
    input  logic               cp_req,
    input  logic               run_allow,
    output logic               run_want,
    output logic               cp_grant,
    output logic               clock_enable,
    output logic               lease_expired
);

    localparam int unsigned DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);

    ch_state_e          state_q;
    logic [LEASE_W-1:0] lease_q;
    logic [DRAIN_W-1:0] drain_q;

    assign run_want = (state_q == StArmed) && cp_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            lease_q       <= '0;
            drain_q       <= '0;
            cp_grant      <= 1'b0;
            clock_enable  <= 1'b0;
            lease_expired <= 1'b0;
        end else begin
            lease_expired <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (tok_load) begin
                        state_q <= StArmed;
                        lease_q <= tok_lease;
                    end
                end
                StArmed: begin
                    if (tok_load) lease_q <= tok_lease;
                    if (cp_req && run_allow) begin
                        state_q      <= StRun;
                        cp_grant     <= 1'b1;
                        clock_enable <= 1'b1;
                    end
                end
                StRun: begin
                    // Only cycles with an active request consume lease.
                    if (!cp_req) begin
                        state_q  <= StDrain;
                        cp_grant <= 1'b0;
                        drain_q  <= DRAIN_LOAD;
                        if (tok_load) lease_q <= tok_lease;
                    end else if (tok_load) begin
                        lease_q <= tok_lease;
                    end else if (lease_q == LEASE_W'(1)) begin
                        state_q       <= StDrain;
                        cp_grant      <= 1'b0;
                        drain_q       <= DRAIN_LOAD;
                        lease_q       <= '0;
                        lease_expired <= 1'b1;
                    end else begin
                        lease_q <= lease_q - LEASE_W'(1);
                    end
                end
                StDrain: begin
                    if (tok_load) lease_q <= tok_lease;
                    if (drain_q == '0) begin
                        clock_enable <= 1'b0;
                        state_q <= ((tok_load ? tok_lease : lease_q) != '0) ? StArmed : StIdle;
                    end else begin
                        drain_q <= drain_q - DRAIN_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/aipp_token_lease_dispatcher.sv
// Multi-channel lease dispatcher: token decode/reject, per-channel lease FSMs and
// optional wake stagger (define AIPP_STAGGER_EN to allow one ARMED->RUN per cycle).
module aipp_token_lease_dispatcher
    import aipp_dispatch_pkg::*;
#(
    parameter int unsigned NUM_CH       = 4,
    parameter int unsigned TOKEN_W      = 128,
    parameter int unsigned LEASE_W      = 16,
    parameter int unsigned DRAIN_CYCLES = 4,
    localparam int unsigned CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               token_valid,
    input  logic [CH_W-1:0]    token_ch,
    input  logic [TOKEN_W-1:0] token_data,
    input  logic [LEASE_W-1:0] token_lease,
    output logic               token_reject,
    input  logic [NUM_CH-1:0]  cp_req,
    output logic [NUM_CH-1:0]  cp_grant,
    output logic [NUM_CH-1:0]  alu_clock_enable,
    output logic [NUM_CH-1:0]  lease_expired
);

    logic              ch_in_range;
    logic              tok_ok;
    logic [NUM_CH-1:0] run_want;
    logic [NUM_CH-1:0] run_allow;

    assign ch_in_range = (32'(token_ch) < NUM_CH);
    assign tok_ok = token_valid && (token_data[TOKEN_LOW_W-1:0] != '0) &&
                    (token_lease != '0) && ch_in_range;

    if (TOKEN_W > TOKEN_LOW_W) begin : g_token_hi
        logic unused_token_hi;
        assign unused_token_hi = ^token_data[TOKEN_W-1:TOKEN_LOW_W];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) token_reject <= 1'b0;
        else     token_reject <= token_valid && !tok_ok;
    end

`ifdef AIPP_STAGGER_EN
    // Lowest-index ARMED channel with a request is the only one woken this cycle.
    always_comb begin
        logic found;
        found     = 1'b0;
        run_allow = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (run_want[i] && !found) begin
                run_allow[i] = 1'b1;
                found        = 1'b1;
            end
        end
    end
`else
    logic unused_run_want;
    assign unused_run_want = ^run_want;
    assign run_allow       = '1;
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        aipp_lease_channel #(
            .LEASE_W      (LEASE_W),
            .DRAIN_CYCLES (DRAIN_CYCLES)
        ) u_ch (
            .clk           (clk),
            .rst           (rst),
            .tok_load      (tok_ok && (token_ch == CH_W'(i))),
            .tok_lease     (token_lease),
            .cp_req        (cp_req[i]),
            .run_allow     (run_allow[i]),
            .run_want      (run_want[i]),
            .cp_grant      (cp_grant[i]),
            .clock_enable  (alu_clock_enable[i]),
            .lease_expired (lease_expired[i])
        );
    end

endmodule

// File: tb/tb_aipp_token_lease_dispatcher.sv
// Scoreboard bench: per-cycle expectations from a lease-rule model, checked at negedge.
module tb_aipp_token_lease_dispatcher;

    localparam int unsigned NUM_CH       = 4;
    localparam int unsigned TOKEN_W      = 128;
    localparam int unsigned LEASE_W      = 16;
    localparam int unsigned DRAIN_CYCLES = 4;
    localparam int unsigned CH_W         = 2;

    localparam int M_IDLE  = 0;
    localparam int M_ARMED = 1;
    localparam int M_RUN   = 2;
    localparam int M_DRAIN = 3;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               token_valid = 1'b0;
    logic [CH_W-1:0]    token_ch = '0;
    logic [TOKEN_W-1:0] token_data = '0;
    logic [LEASE_W-1:0] token_lease = '0;
    logic               token_reject;
    logic [NUM_CH-1:0]  cp_req = '0;
    logic [NUM_CH-1:0]  cp_grant;
    logic [NUM_CH-1:0]  alu_clock_enable;
    logic [NUM_CH-1:0]  lease_expired;

    aipp_token_lease_dispatcher #(
        .NUM_CH       (NUM_CH),
        .TOKEN_W      (TOKEN_W),
        .LEASE_W      (LEASE_W),
        .DRAIN_CYCLES (DRAIN_CYCLES)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .token_valid      (token_valid),
        .token_ch         (token_ch),
        .token_data       (token_data),
        .token_lease      (token_lease),
        .token_reject     (token_reject),
        .cp_req           (cp_req),
        .cp_grant         (cp_grant),
        .alu_clock_enable (alu_clock_enable),
        .lease_expired    (lease_expired)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NUM_CH-1:0] grant;
        logic [NUM_CH-1:0] clk_en;
        logic [NUM_CH-1:0] expired;
        logic              reject;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    int m_mode  [NUM_CH];
    int m_lease [NUM_CH];
    int m_drain [NUM_CH];

    int cnt_ch    = 0;
    int cnt_grant = 0;
    int cnt_clk   = 0;
    int cnt_exp   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_mode[c]  = M_IDLE;
            m_lease[c] = 0;
            m_drain[c] = 0;
        end
    endtask

    // Drive one cycle of stimulus, advance the model, queue the expected outputs.
    task automatic step(input logic tv, input int tch, input logic [TOKEN_W-1:0] td,
                        input int tl, input logic [NUM_CH-1:0] req);
        exp_t e;
        bit   acc;
        int   winner;
        token_valid = tv;
        token_ch    = tch[CH_W-1:0];
        token_data  = td;
        token_lease = tl[LEASE_W-1:0];
        cp_req      = req;
        acc      = tv && (td[63:0] != 64'd0) && (tl != 0) && (tch < NUM_CH);
        e.reject = tv && !acc;
        winner   = -1;
`ifdef AIPP_STAGGER_EN
        for (int c = 0; c < NUM_CH; c++)
            if (winner < 0 && m_mode[c] == M_ARMED && req[c]) winner = c;
`endif
        for (int c = 0; c < NUM_CH; c++) begin
            bit refr;
            bit may_run;
            refr = acc && (tch == c);
`ifdef AIPP_STAGGER_EN
            may_run = (c == winner);
`else
            may_run = 1'b1;
`endif
            e.expired[c] = 1'b0;
            case (m_mode[c])
                M_IDLE: if (refr) begin m_mode[c] = M_ARMED; m_lease[c] = tl; end
                M_ARMED: begin
                    if (refr) m_lease[c] = tl;
                    if (req[c] && may_run) m_mode[c] = M_RUN;
                end
                M_RUN: begin
                    if (refr) m_lease[c] = tl;
                    if (!req[c]) begin
                        m_mode[c]  = M_DRAIN;
                        m_drain[c] = DRAIN_CYCLES;
                    end else if (!refr) begin
                        m_lease[c]--;
                        if (m_lease[c] == 0) begin
                            m_mode[c]    = M_DRAIN;
                            m_drain[c]   = DRAIN_CYCLES;
                            e.expired[c] = 1'b1;
                        end
                    end
                end
                default: begin
                    if (refr) m_lease[c] = tl;
                    m_drain[c]--;
                    if (m_drain[c] == 0) m_mode[c] = (m_lease[c] != 0) ? M_ARMED : M_IDLE;
                end
            endcase
            e.grant[c]  = (m_mode[c] == M_RUN);
            e.clk_en[c] = (m_mode[c] == M_RUN) || (m_mode[c] == M_DRAIN);
        end
        exp_q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    task automatic idle_steps(input int n, input logic [NUM_CH-1:0] req);
        for (int i = 0; i < n; i++) step(1'b0, 0, '0, 0, req);
    endtask

    task automatic clear_counts(input int ch);
        cnt_ch    = ch;
        cnt_grant = 0;
        cnt_clk   = 0;
        cnt_exp   = 0;
    endtask

    // Monitor: pops one expectation per cycle and counts activity on one channel.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (cp_grant[cnt_ch])         cnt_grant++;
            if (alu_clock_enable[cnt_ch]) cnt_clk++;
            if (lease_expired[cnt_ch])    cnt_exp++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("cp_grant", 32'(cp_grant), 32'(e.grant));
                chk("alu_clock_enable", 32'(alu_clock_enable), 32'(e.clk_en));
                chk("lease_expired", 32'(lease_expired), 32'(e.expired));
                chk("token_reject", 32'(token_reject), 32'(e.reject));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int first [NUM_CH];
        logic [TOKEN_W-1:0] td;
        logic [NUM_CH-1:0]  rq;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("reset_outputs", {alu_clock_enable, cp_grant, lease_expired}, 32'd0);
        chk("reset_reject", 32'(token_reject), 32'd0);
        rst = 1'b0;

        // Lease 5 on channel 2 with request held: 5 grant, 9 clock, one expiry.
        clear_counts(2);
        step(1'b1, 2, 128'h1, 5, 4'b0100);
        idle_steps(13, 4'b0100);
        chk("ch2_grant_cycles", cnt_grant, 5);
        chk("ch2_clock_cycles", cnt_clk, 9);
        chk("ch2_expired_pulses", cnt_exp, 1);

        // Rejects: zero low field, zero lease; an invalid strobe must not reject.
        step(1'b1, 0, {64'hdead, 64'h0}, 3, 4'hF);
        step(1'b1, 1, 128'h5, 0, 4'hF);
        step(1'b0, 3, 128'h7, 4, 4'hF);
        idle_steps(2, 4'hF);

        // Refresh in the expiry cycle of a lease-2 RUN extends it by 3.
        clear_counts(1);
        step(1'b1, 1, 128'h9, 2, 4'b0000);
        idle_steps(2, 4'b0010);
        step(1'b1, 1, 128'h9, 3, 4'b0010);
        idle_steps(9, 4'b0010);
        chk("refresh_grant_cycles", cnt_grant, 5);
        chk("refresh_expired_pulses", cnt_exp, 1);

        // Request drop after 2 RUN cycles of lease 10, then resume with 8 left.
        clear_counts(3);
        step(1'b1, 3, 128'h3, 10, 4'b0000);
        idle_steps(3, 4'b1000);
        idle_steps(5, 4'b0000);
        idle_steps(14, 4'b1000);
        chk("drop_grant_cycles", cnt_grant, 11);
        chk("drop_clock_cycles", cnt_clk, 19);
        chk("drop_expired_pulses", cnt_exp, 1);
        idle_steps(2, 4'b0000);

        // Reset asserted mid-DRAIN clears outputs asynchronously.
        step(1'b1, 0, 128'h11, 10, 4'b0000);
        idle_steps(3, 4'b0001);
        idle_steps(2, 4'b0000);
        rst = 1'b1;
        #1;
        chk("async_reset_outputs", {alu_clock_enable, cp_grant, lease_expired}, 32'd0);
        model_reset();
        begin
            exp_t z;
            z.grant = '0; z.clk_en = '0; z.expired = '0; z.reject = 1'b0;
            exp_q.push_back(z);
        end
        @(negedge clk);
        #1;
        rst = 1'b0;
        idle_steps(3, 4'b0001);

        // Wake all four channels at once.
        for (int c = 0; c < NUM_CH; c++) step(1'b1, c, 128'h21, 20, 4'b0000);
        for (int c = 0; c < NUM_CH; c++) first[c] = -1;
        for (int k = 0; k < 6; k++) begin
            step(1'b0, 0, '0, 0, 4'hF);
            for (int c = 0; c < NUM_CH; c++)
                if (first[c] < 0 && cp_grant[c]) first[c] = k;
        end
        for (int c = 0; c < NUM_CH; c++) begin
`ifdef AIPP_STAGGER_EN
            chk("wake_cycle", first[c], c);
`else
            chk("wake_cycle", first[c], 0);
`endif
        end
        idle_steps(6, 4'b0000);
        for (int c = 0; c < NUM_CH; c++) step(1'b1, c, 128'h1, 1, 4'hF);
        idle_steps(8, 4'b0000);

        // Randomised traffic against the model.
        rq = '0;
        for (int i = 0; i < 400; i++) begin
            for (int c = 0; c < NUM_CH; c++)
                if ($urandom_range(0, 7) == 0) rq[c] = ~rq[c];
            td = {$urandom(), $urandom(), $urandom(), $urandom()};
            if ($urandom_range(0, 3) == 0) td[63:0] = 64'd0;
            step($urandom_range(0, 1) == 1, $urandom_range(0, NUM_CH - 1), td,
                 $urandom_range(0, 8), rq);
        end
        idle_steps(12, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
